// File: rtl/t03_dpu_pkg.sv
// t03_dpu_pkg: shared DPU register addresses, update-sequencer states and status-word layout
package t03_dpu_pkg;

    localparam logic [31:0] STAT_ADDR = 32'hFF000003;
    localparam logic [31:0] POS_ADDR  = 32'hFF000004;
    localparam logic [31:0] IDLE_ADDR = 32'h00000000;

    typedef enum logic [1:0] {
        IDLE,
        SEND_STAT,
        SEND_POS,
        DONE
    } dpu_state_t;

    typedef struct packed {
        logic [1:0] game_state;
        logic [1:0] p1_state;
        logic [1:0] p2_state;
        logic [4:0] p1_health;
        logic [4:0] p2_health;
    } stat_word_t;

endpackage

// File: rtl/t03_dpu_stage_regs.sv
// t03_dpu_stage_regs: CPU write decode into status/position staging registers with dirty tracking
module t03_dpu_stage_regs
    import t03_dpu_pkg::*;
#(
    parameter logic [31:0] STAT_A = STAT_ADDR,
    parameter logic [31:0] POS_A  = POS_ADDR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_wen_i,
    input  logic [31:0] cpu_addr_i,
    input  logic [31:0] cpu_data_i,
    input  logic        clr_i,
    output logic [31:0] stat_stage_o,
    output logic [31:0] pos_stage_o,
    output logic        stat_dirty_o,
    output logic        pos_dirty_o
);

    logic [31:0] stat_stage_q, stat_stage_d;
    logic [31:0] pos_stage_q, pos_stage_d;
    logic        stat_dirty_q, stat_dirty_d;
    logic        pos_dirty_q, pos_dirty_d;
    logic        stat_wr, pos_wr;

    // a write landing in the snapshot cycle keeps its dirty bit for the next frame
    always_comb begin
        stat_wr      = cpu_wen_i && (cpu_addr_i == STAT_A);
        pos_wr       = cpu_wen_i && (cpu_addr_i == POS_A);
        stat_stage_d = stat_wr ? cpu_data_i : stat_stage_q;
        pos_stage_d  = pos_wr ? cpu_data_i : pos_stage_q;
        stat_dirty_d = stat_wr || (stat_dirty_q && !clr_i);
        pos_dirty_d  = pos_wr || (pos_dirty_q && !clr_i);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_stage_q <= '0;
            pos_stage_q  <= '0;
            stat_dirty_q <= 1'b0;
            pos_dirty_q  <= 1'b0;
        end else begin
            stat_stage_q <= stat_stage_d;
            pos_stage_q  <= pos_stage_d;
            stat_dirty_q <= stat_dirty_d;
            pos_dirty_q  <= pos_dirty_d;
        end
    end

    assign stat_stage_o = stat_stage_q;
    assign pos_stage_o  = pos_stage_q;
    assign stat_dirty_o = stat_dirty_q;
    assign pos_dirty_o  = pos_dirty_q;

endmodule

// File: rtl/t03_dpu_update_sequencer.sv
// t03_dpu_update_sequencer: once-per-frame replay of changed status/position words to the DPU decoder
module t03_dpu_update_sequencer
    import t03_dpu_pkg::*;
#(
    parameter logic [31:0] STAT_A = STAT_ADDR,
    parameter logic [31:0] POS_A  = POS_ADDR,
    parameter logic [31:0] IDLE_A = IDLE_ADDR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_wen,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_data,
    input  logic        frame_sync,
    input  logic        out_ready,
    output logic        out_valid,
    output logic [31:0] out_addr,
    output logic [31:0] out_data,
    output logic        busy,
    output logic        frame_done,
    output logic [7:0]  overrun_cnt
);

    dpu_state_t  state_q, state_d;
    logic [31:0] stat_stage, pos_stage;
    logic        stat_dirty, pos_dirty;
    logic        take;
    logic [31:0] snap_stat_q, snap_stat_d;
    logic [31:0] snap_pos_q, snap_pos_d;
    logic        snap_stat_en_q, snap_stat_en_d;
    logic        snap_pos_en_q, snap_pos_en_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] out_addr_q, out_addr_d;
    logic [31:0] out_data_q, out_data_d;
    logic        busy_q, busy_d;
    logic        frame_done_q, frame_done_d;
    logic [7:0]  overrun_q, overrun_d;

    t03_dpu_stage_regs #(
        .STAT_A (STAT_A),
        .POS_A  (POS_A)
    ) u_stage (
        .clk          (clk),
        .rst          (rst),
        .cpu_wen_i    (cpu_wen),
        .cpu_addr_i   (cpu_addr),
        .cpu_data_i   (cpu_data),
        .clr_i        (take),
        .stat_stage_o (stat_stage),
        .pos_stage_o  (pos_stage),
        .stat_dirty_o (stat_dirty),
        .pos_dirty_o  (pos_dirty)
    );

    // outputs are decoded from the next state so they register alongside it
    always_comb begin
        take           = (state_q == IDLE) && frame_sync && (stat_dirty || pos_dirty);
        snap_stat_d    = take ? stat_stage : snap_stat_q;
        snap_pos_d     = take ? pos_stage : snap_pos_q;
        snap_stat_en_d = take ? stat_dirty : snap_stat_en_q;
        snap_pos_en_d  = take ? pos_dirty : snap_pos_en_q;
        state_d        = state_q;
        case (state_q)
            IDLE:      if (take) state_d = snap_stat_en_d ? SEND_STAT : SEND_POS;
            SEND_STAT: if (out_valid_q && out_ready) state_d = snap_pos_en_q ? SEND_POS : DONE;
            SEND_POS:  if (out_valid_q && out_ready) state_d = DONE;
            default:   state_d = IDLE;
        endcase
        out_valid_d  = (state_d == SEND_STAT) || (state_d == SEND_POS);
        out_addr_d   = (state_d == SEND_STAT) ? STAT_A :
                       (state_d == SEND_POS)  ? POS_A  : IDLE_A;
        out_data_d   = (state_d == SEND_STAT) ? snap_stat_d :
                       (state_d == SEND_POS)  ? snap_pos_d  : 32'h0;
        busy_d       = state_d != IDLE;
        frame_done_d = state_d == DONE;
        overrun_d    = (frame_sync && state_q != IDLE && overrun_q != 8'hFF) ? overrun_q + 8'd1 : overrun_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            snap_stat_q    <= '0;
            snap_pos_q     <= '0;
            snap_stat_en_q <= 1'b0;
            snap_pos_en_q  <= 1'b0;
            out_valid_q    <= 1'b0;
            out_addr_q     <= IDLE_A;
            out_data_q     <= '0;
            busy_q         <= 1'b0;
            frame_done_q   <= 1'b0;
            overrun_q      <= '0;
        end else begin
            state_q        <= state_d;
            snap_stat_q    <= snap_stat_d;
            snap_pos_q     <= snap_pos_d;
            snap_stat_en_q <= snap_stat_en_d;
            snap_pos_en_q  <= snap_pos_en_d;
            out_valid_q    <= out_valid_d;
            out_addr_q     <= out_addr_d;
            out_data_q     <= out_data_d;
            busy_q         <= busy_d;
            frame_done_q   <= frame_done_d;
            overrun_q      <= overrun_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_addr    = out_addr_q;
    assign out_data    = out_data_q;
    assign busy        = busy_q;
    assign frame_done  = frame_done_q;
    assign overrun_cnt = overrun_q;

endmodule

// File: tb/tb_t03_dpu_update_sequencer.sv
// tb_t03_dpu_update_sequencer: directed self-checking bench for the DPU update sequencer
module tb_t03_dpu_update_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_wen = 1'b0;
    logic [31:0] cpu_addr = '0;
    logic [31:0] cpu_data = '0;
    logic        frame_sync = 1'b0;
    logic        out_ready = 1'b0;
    logic        out_valid;
    logic [31:0] out_addr;
    logic [31:0] out_data;
    logic        busy;
    logic        frame_done;
    logic [7:0]  overrun_cnt;
    int          passed = 0;
    int          total = 0;
    int          fails = 0;

    localparam logic [31:0] SA = 32'hFF000003;
    localparam logic [31:0] PA = 32'hFF000004;

    t03_dpu_update_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .cpu_wen     (cpu_wen),
        .cpu_addr    (cpu_addr),
        .cpu_data    (cpu_data),
        .frame_sync  (frame_sync),
        .out_ready   (out_ready),
        .out_valid   (out_valid),
        .out_addr    (out_addr),
        .out_data    (out_data),
        .busy        (busy),
        .frame_done  (frame_done),
        .overrun_cnt (overrun_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required finish before 200000");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: got %h required %h", tag, got, exp);
        end
    endtask

    task automatic bus(input string tag, input logic v, input logic [31:0] a, input logic [31:0] d);
        check({tag, "_valid"}, {31'b0, out_valid}, {31'b0, v});
        check({tag, "_addr"}, out_addr, a);
        check({tag, "_data"}, out_data, d);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        cpu_wen = 1'b1; cpu_addr = a; cpu_data = d;
        tick();
        cpu_wen = 1'b0; cpu_addr = '0; cpu_data = '0;
    endtask

    initial begin
        tick(); tick();
        bus("rst", 1'b0, 32'h0, 32'h0);
        check("rst_busy", {31'b0, busy}, 32'h0);
        check("rst_done", {31'b0, frame_done}, 32'h0);
        check("rst_ovr", {24'b0, overrun_cnt}, 32'h0);
        rst = 1'b0;
        // single status word, ready always high
        out_ready = 1'b1;
        wr(SA, 32'h0000C3E7);
        bus("t1_pre", 1'b0, 32'h0, 32'h0);
        frame_sync = 1'b1;
        tick();
        frame_sync = 1'b0;
        bus("t1_stat", 1'b1, SA, 32'h0000C3E7);
        check("t1_busy", {31'b0, busy}, 32'h1);
        tick();
        bus("t1_after", 1'b0, 32'h0, 32'h0);
        check("t1_done", {31'b0, frame_done}, 32'h1);
        tick();
        check("t1_done_low", {31'b0, frame_done}, 32'h0);
        check("t1_idle", {31'b0, busy}, 32'h0);
        // both words with a three-cycle stall on the status write
        out_ready = 1'b0;
        wr(SA, 32'h00008421);
        wr(PA, 32'h10203040);
        bus("t2_pre", 1'b0, 32'h0, 32'h0);
        frame_sync = 1'b1;
        tick();
        frame_sync = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus("t2_stall", 1'b1, SA, 32'h00008421);
            if (i == 3) out_ready = 1'b1;
            tick();
        end
        bus("t2_pos", 1'b1, PA, 32'h10203040);
        check("t2_pos_nodone", {31'b0, frame_done}, 32'h0);
        tick();
        bus("t2_after", 1'b0, 32'h0, 32'h0);
        check("t2_done", {31'b0, frame_done}, 32'h1);
        tick();
        check("t2_idle", {31'b0, busy}, 32'h0);
        // frame_sync with nothing dirty
        frame_sync = 1'b1;
        tick();
        frame_sync = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check("t3_quiet", {30'b0, out_valid, busy}, 32'h0);
            tick();
        end
        // overrun saturation while stalled in SEND_POS
        out_ready = 1'b0;
        wr(PA, 32'hCAFEBABE);
        frame_sync = 1'b1;
        tick();
        bus("t4_pos", 1'b1, PA, 32'hCAFEBABE);
        check("t4_ovr0", {24'b0, overrun_cnt}, 32'h0);
        tick();
        frame_sync = 1'b0;
        check("t4_ovr1", {24'b0, overrun_cnt}, 32'h1);
        for (int i = 1; i < 300; i++) begin
            frame_sync = 1'b1;
            tick();
            frame_sync = 1'b0;
            tick();
        end
        check("t4_ovr_sat", {24'b0, overrun_cnt}, 32'hFF);
        bus("t4_held", 1'b1, PA, 32'hCAFEBABE);
        out_ready = 1'b1;
        tick();
        bus("t4_after", 1'b0, 32'h0, 32'h0);
        check("t4_done", {31'b0, frame_done}, 32'h1);
        tick();
        check("t4_idle", {31'b0, busy}, 32'h0);
        check("t4_ovr_keep", {24'b0, overrun_cnt}, 32'hFF);
        // write colliding with the snapshot goes out on the following frame
        wr(SA, 32'h00005555);
        cpu_wen = 1'b1; cpu_addr = SA; cpu_data = 32'h0000AAAA; frame_sync = 1'b1;
        tick();
        cpu_wen = 1'b0; cpu_addr = '0; cpu_data = '0; frame_sync = 1'b0;
        bus("t5_old", 1'b1, SA, 32'h00005555);
        tick();
        check("t5_done1", {31'b0, frame_done}, 32'h1);
        tick();
        frame_sync = 1'b1;
        tick();
        frame_sync = 1'b0;
        bus("t5_new", 1'b1, SA, 32'h0000AAAA);
        tick();
        check("t5_done2", {31'b0, frame_done}, 32'h1);
        tick();
        // async reset during a stalled status write
        out_ready = 1'b0;
        wr(SA, 32'h00001111);
        frame_sync = 1'b1;
        tick();
        frame_sync = 1'b0;
        bus("t6_pre", 1'b1, SA, 32'h00001111);
        #2 rst = 1'b1;
        #1;
        bus("t6_rst", 1'b0, 32'h0, 32'h0);
        check("t6_busy", {31'b0, busy}, 32'h0);
        check("t6_ovr", {24'b0, overrun_cnt}, 32'h0);
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("t6_nodone", {31'b0, frame_done}, 32'h0);
            tick();
        end
        frame_sync = 1'b1;
        tick();
        frame_sync = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("t6_quiet", {29'b0, out_valid, busy, frame_done}, 32'h0);
            tick();
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
